// File: rtl/seg7_scan_driver.sv
// Four-digit 7-segment scan driver: 14-bit binary to BCD via serial double-dabble, multiplexed digit output.
// Optional leading-zero blanking is enabled by defining SEG7_BLANK_EN.
module seg7_scan_driver #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] bin_in,
   input  logic        load,
   output logic        busy,
   output logic        ovf,
   output logic [3:0]  digit_val,
   output logic [3:0]  digit_sel
);

   localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   generate
      if (SCAN_DIV < 1) begin : g_bad_scan_div
         $error("seg7_scan_driver: SCAN_DIV must be >= 1");
      end
   endgenerate

   typedef enum logic {IDLE, CONV} state_t;

   state_t        r_state;
   logic [13:0]   r_bin;
   logic [14:0]   r_bcd;
   logic [3:0]    r_iter;
   logic [15:0]   r_disp;
   logic          r_busy;
   logic          r_ovf;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;
   logic [3:0]    r_sel;
   logic [3:0]    r_val;

   logic [13:0]   w_clamped;
   logic [14:0]   w_adj;
   logic [15:0]   w_bcd_next;
   logic [3:0]    w_nib;
   logic [3:0]    w_val_next;

   assign w_clamped = (bin_in > 14'd9999) ? 14'd9999 : bin_in;

   // Top BCD nibble never exceeds 4 before a shift for inputs <= 9999, so it needs no add-3.
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 3; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
   end

   assign w_bcd_next = {w_adj, r_bin[13]};

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_iter  <= '0;
         r_disp  <= '0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (load) begin
                  r_bin   <= w_clamped;
                  r_ovf   <= (bin_in > 14'd9999);
                  r_bcd   <= '0;
                  r_iter  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= CONV;
               end
            end
            CONV: begin
               r_bcd  <= w_bcd_next[14:0];
               r_bin  <= {r_bin[12:0], 1'b0};
               r_iter <= r_iter + 4'd1;
               if (r_iter == 4'd13) begin
                  r_disp  <= w_bcd_next;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (r_presc == PRESC_LAST) begin
         r_presc <= '0;
         r_idx   <= r_idx + 2'd1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

`ifdef SEG7_BLANK_EN
   logic w_blank;

   // NOTE: default assignment first keeps this combinational block latch-free.
   always_comb begin
      w_blank = 1'b0;
      case (r_idx)
         2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
         2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
         2'd3:    w_blank = (r_disp[15:12] == 4'd0);
         default: w_blank = 1'b0;
      endcase
   end

   assign w_val_next = w_blank ? 4'd15 : w_nib;
`else
   assign w_val_next = w_nib;
`endif

   // Select and value are registered together so they always refer to the same digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= 4'b0001;
         r_val <= 4'd0;
      end else begin
         r_sel <= 4'b0001 << r_idx;
         r_val <= w_val_next;
      end
   end

   assign busy      = r_busy;
   assign ovf       = r_ovf;
   assign digit_sel = r_sel;
   assign digit_val = r_val;

endmodule
